mem_data_bridge: RTL and testbench

Data-side bus bridge directly downstream of the MEM stage. It converts MEM's single-cycle RAM strobe interface (ram_ce/ram_we/ram_sel/ram_addr/ram_wdata) into a SRAM-like req/addr_ok/data_ok transaction. It returns read data to MEM's ram_data input and raises a stall request that freezes the pipeline until the access completes. Exception flushes are absorbed without corrupting the in-flight bus transaction.

---
 rtl/mem_bridge_pkg.sv | 25 ++
 rtl/mem_data_bridge_if.sv | 23 ++
 rtl/mem_sel_decode.sv | 25 ++
 rtl/mem_data_bridge.sv | 108 ++++++++++
 tb/tb_mem_data_bridge.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the MEM-side data bridge
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // kseg0/kseg1 both alias the low 512 MB of physical memory
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    function automatic logic [31:0] kseg_map(input logic [31:0] vaddr, input bit enable);
        if (enable && vaddr[31:30] == 2'b10) begin
            return vaddr & KSEG_MASK;
        end
        return vaddr;
    endfunction

endpackage

// File: rtl/mem_data_bridge_if.sv
// rtl/mem_data_bridge_if.sv - SRAM-like req/addr_ok/data_ok data bus
interface mem_data_bridge_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );

endinterface

// File: rtl/mem_sel_decode.sv
// rtl/mem_sel_decode.sv - byte-lane select to bus size and low address bits
module mem_sel_decode
    import mem_bridge_pkg::*;
(
    input  logic [3:0] sel,
    output logic [1:0] size,
    output logic [1:0] addr_lo
);

    // Unsupported lane patterns fall back to an aligned word access
    always_comb begin
        size    = SIZE_W;
        addr_lo = 2'b00;
        case (sel)
            4'b0001: begin size = SIZE_B; addr_lo = 2'b00; end
            4'b0010: begin size = SIZE_B; addr_lo = 2'b01; end
            4'b0100: begin size = SIZE_B; addr_lo = 2'b10; end
            4'b1000: begin size = SIZE_B; addr_lo = 2'b11; end
            4'b0011: begin size = SIZE_H; addr_lo = 2'b00; end
            4'b1100: begin size = SIZE_H; addr_lo = 2'b10; end
            default: begin size = SIZE_W; addr_lo = 2'b00; end
        endcase
    end

endmodule

// File: rtl/mem_data_bridge.sv
// rtl/mem_data_bridge.sv - MEM strobe interface to SRAM-like bus, with stall and flush absorption
module mem_data_bridge
    import mem_bridge_pkg::*;
#(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ram_ce_i,
    input  logic                ram_we_i,
    input  logic [3:0]          ram_sel_i,
    input  logic [31:0]         ram_addr_i,
    input  logic [31:0]         ram_wdata_i,
    input  logic                flush_i,
    output logic [31:0]         ram_rdata_o,
    output logic                stall_req_o,
    mem_data_bridge_if.master   bus
);

    state_t      state, state_next;
    logic        cancel, cancel_next;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  dec_size;
    logic [1:0]  dec_lo;
    logic [31:0] mapped_addr;
    logic        capture;
    logic        cancel_now;
    logic        rdata_load;

    mem_sel_decode u_sel_decode (
        .sel     (ram_sel_i),
        .size    (dec_size),
        .addr_lo (dec_lo)
    );

    assign mapped_addr = (kseg_map(ram_addr_i, KSEG_MAP) & ~32'h3) | {30'b0, dec_lo};
    assign capture     = (state == IDLE) && ram_ce_i && !flush_i;
    // A flush arriving together with data_ok must still discard that response
    assign cancel_now  = cancel || flush_i;
    assign rdata_load  = (state == WAIT) && bus.data_data_ok && !wr_q && !cancel_now;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (capture) state_next = REQ;
            REQ:  if (bus.data_addr_ok) state_next = WAIT;
            WAIT: if (bus.data_data_ok) state_next = cancel_now ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cancel_next = cancel;
        if (state_next == IDLE) begin
            cancel_next = 1'b0;
        end else if (flush_i && (state == REQ || state == WAIT)) begin
            cancel_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cancel <= 1'b0;
        end else begin
            state  <= state_next;
            cancel <= cancel_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (capture) begin
            wr_q    <= ram_we_i;
            size_q  <= dec_size;
            addr_q  <= mapped_addr;
            wdata_q <= ram_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= 32'h0;
        end else if (rdata_load) begin
            rdata_q <= bus.data_rdata;
        end
    end

    assign bus.data_req   = (state == REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    assign ram_rdata_o = rdata_q;
    assign stall_req_o = rst_i && ram_ce_i && (state != DONE);

endmodule

// File: tb/tb_mem_data_bridge.sv
// tb/tb_mem_data_bridge.sv - directed self-checking bench for mem_data_bridge
module tb_mem_data_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ce, we, flush;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_m, rdata_n;
    logic        stall_m, stall_n;

    int n_checks = 0;
    int n_errors = 0;

    mem_data_bridge_if bus_m ();
    mem_data_bridge_if bus_n ();

    assign bus_n.data_addr_ok = bus_m.data_addr_ok;
    assign bus_n.data_data_ok = bus_m.data_data_ok;
    assign bus_n.data_rdata   = bus_m.data_rdata;

    mem_data_bridge #(.KSEG_MAP(1'b1)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ram_ce_i    (ce),
        .ram_we_i    (we),
        .ram_sel_i   (sel),
        .ram_addr_i  (addr),
        .ram_wdata_i (wdata),
        .flush_i     (flush),
        .ram_rdata_o (rdata_m),
        .stall_req_o (stall_m),
        .bus         (bus_m)
    );

    mem_data_bridge #(.KSEG_MAP(1'b0)) u_dut_nomap (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ram_ce_i    (ce),
        .ram_we_i    (we),
        .ram_sel_i   (sel),
        .ram_addr_i  (addr),
        .ram_wdata_i (wdata),
        .flush_i     (flush),
        .ram_rdata_o (rdata_n),
        .stall_req_o (stall_n),
        .bus         (bus_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Runs one access starting at a negedge in IDLE; returns in the DONE cycle (or on timeout)
    task automatic do_access(
        input  logic        w,
        input  logic [3:0]  s,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  int          a_dly,
        input  int          d_dly,
        input  logic [31:0] bus_rd,
        output int          n_stall,
        output int          n_req,
        output logic [31:0] req_addr,
        output logic [31:0] req_addr_n,
        output logic [1:0]  req_size,
        output logic        req_wr,
        output logic [31:0] req_wdata,
        output logic        addr_stable,
        output logic        done
    );
        int   wait_n;
        logic in_wait;
        n_stall = 0; n_req = 0; wait_n = 0; in_wait = 1'b0; done = 1'b0; addr_stable = 1'b1;
        req_addr = '0; req_addr_n = '0; req_size = '0; req_wr = 1'b0; req_wdata = '0;
        ce = 1'b1; we = w; sel = s; addr = a; wdata = wd;
        bus_m.data_rdata = bus_rd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            bus_m.data_addr_ok = 1'b0;
            bus_m.data_data_ok = 1'b0;
            if (stall_m) n_stall++;
            else done = 1'b1;
            if (bus_m.data_req) begin
                n_req++;
                if (n_req == 1) begin
                    req_addr   = bus_m.data_addr;
                    req_addr_n = bus_n.data_addr;
                    req_size   = bus_m.data_size;
                    req_wr     = bus_m.data_wr;
                    req_wdata  = bus_m.data_wdata;
                end else if (bus_m.data_addr !== req_addr) begin
                    addr_stable = 1'b0;
                end
                if (n_req == a_dly + 1) begin
                    bus_m.data_addr_ok = 1'b1;
                    in_wait = 1'b1;
                end
            end else if (in_wait) begin
                wait_n++;
                if (wait_n == d_dly) bus_m.data_data_ok = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        ce = 1'b0;
    endtask

    int          ns, nr;
    logic [31:0] ra, ran, rwd;
    logic [1:0]  rsz;
    logic        rwr, stab, dn;

    logic [3:0]  tbl_sel  [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0101};
    logic [31:0] tbl_addr [4] = '{32'h0000_2000, 32'h0000_2001, 32'h0000_2003, 32'h0000_2000};
    logic [1:0]  tbl_size [4] = '{2'd0, 2'd0, 2'd0, 2'd2};

    initial begin
        rst_i = 1'b0; ce = 1'b1; we = 1'b0; flush = 1'b0; sel = 4'hF;
        addr = 32'h8000_0010; wdata = 32'h0;
        bus_m.data_addr_ok = 1'b0; bus_m.data_data_ok = 1'b0; bus_m.data_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {31'b0, bus_m.data_req}, 32'h0);
        check("rst_wr",    {31'b0, bus_m.data_wr},  32'h0);
        check("rst_size",  {30'b0, bus_m.data_size}, 32'h0);
        check("rst_addr",  bus_m.data_addr,  32'h0);
        check("rst_wdata", bus_m.data_wdata, 32'h0);
        check("rst_rdata", rdata_m, 32'h0);
        check("rst_stall", {31'b0, stall_m}, 32'h0);
        ce = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // word load, best-case timing
        do_access(1'b0, 4'hF, 32'h8000_0010, 32'h0, 0, 1, 32'hDEAD_BEEF,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("wl_done",  {31'b0, dn}, 32'h1);
        check("wl_stall", ns, 32'd3);
        check("wl_addr",  ra, 32'h0000_0010);
        check("wl_addr_nomap", ran, 32'h8000_0010);
        check("wl_size",  {30'b0, rsz}, 32'd2);
        check("wl_wr",    {31'b0, rwr}, 32'h0);
        check("wl_rdata", rdata_m, 32'hDEAD_BEEF);
        check("wl_rdata_nomap", rdata_n, 32'hDEAD_BEEF);
        @(negedge clk);

        // byte store leaves read data alone
        do_access(1'b1, 4'b0100, 32'hA000_1003, 32'h0012_0000, 0, 1, 32'h5555_5555,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("bs_done",  {31'b0, dn}, 32'h1);
        check("bs_stall", ns, 32'd3);
        check("bs_addr",  ra, 32'h0000_1002);
        check("bs_size",  {30'b0, rsz}, 32'd0);
        check("bs_wr",    {31'b0, rwr}, 32'h1);
        check("bs_wdata", rwd, 32'h0012_0000);
        check("bs_rdata", rdata_m, 32'hDEAD_BEEF);
        @(negedge clk);

        // slow bus: addr_ok on 5th REQ cycle, data_ok 3 cycles after that
        do_access(1'b0, 4'b0011, 32'h8000_0106, 32'h0, 4, 3, 32'h0BAD_F00D,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("sl_done",   {31'b0, dn}, 32'h1);
        check("sl_req",    nr, 32'd5);
        check("sl_stable", {31'b0, stab}, 32'h1);
        check("sl_stall",  ns, 32'd9);
        check("sl_addr",   ra, 32'h0000_0104);
        check("sl_size",   {30'b0, rsz}, 32'd1);
        check("sl_rdata",  rdata_m, 32'h0BAD_F00D);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, tbl_sel[i], 32'h0000_2000, 32'h0, 0, 1, 32'h0000_0100 + i,
                      ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
            check($sformatf("tbl%0d_addr", i), ra, tbl_addr[i]);
            check($sformatf("tbl%0d_size", i), {30'b0, rsz}, {30'b0, tbl_size[i]});
            @(negedge clk);
        end

        // mapping disabled on the second instance
        do_access(1'b0, 4'hF, 32'h8000_0000, 32'h0, 0, 1, 32'h1111_2222,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("km_addr_map",   ra,  32'h0000_0000);
        check("km_addr_nomap", ran, 32'h8000_0000);
        @(negedge clk);
        do_access(1'b0, 4'b1100, 32'h8000_0000, 32'h0, 0, 1, 32'h3333_4444,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("kh_addr_nomap", ran, 32'h8000_0002);
        check("kh_size", {30'b0, rsz}, 32'd1);
        @(negedge clk);

        // flush in IDLE issues nothing
        ce = 1'b1; flush = 1'b1; addr = 32'h8000_0030; sel = 4'hF;
        @(negedge clk);
        ce = 1'b0; flush = 1'b0;
        #1 check("fi_req0", {31'b0, bus_m.data_req}, 32'h0);
        @(negedge clk);
        #1 check("fi_req1", {31'b0, bus_m.data_req}, 32'h0);

        // flush in WAIT: bus completes, result dropped, no DONE cycle
        @(negedge clk);
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h8000_0020;
        @(negedge clk);
        #1 check("fw_req", {31'b0, bus_m.data_req}, 32'h1);
        bus_m.data_addr_ok = 1'b1;
        @(negedge clk);
        #1 bus_m.data_addr_ok = 1'b0; flush = 1'b1;
        check("fw_wait_stall", {31'b0, stall_m}, 32'h1);
        @(negedge clk);
        #1 flush = 1'b0; bus_m.data_data_ok = 1'b1; bus_m.data_rdata = 32'h1234_5678;
        check("fw_drain_stall", {31'b0, stall_m}, 32'h1);
        @(negedge clk);
        #1 bus_m.data_data_ok = 1'b0;
        check("fw_nodone_stall", {31'b0, stall_m}, 32'h1);
        check("fw_idle_req", {31'b0, bus_m.data_req}, 32'h0);
        ce = 1'b0;
        @(negedge clk);
        #1 check("fw_rdata", rdata_m, 32'h3333_4444);
        check("fw_req_after", {31'b0, bus_m.data_req}, 32'h0);

        // async reset in REQ
        @(negedge clk);
        ce = 1'b1; addr = 32'h8000_0040; sel = 4'hF;
        @(negedge clk);
        #1 check("rr_req", {31'b0, bus_m.data_req}, 32'h1);
        #1 rst_i = 1'b0;
        #1 check("rr_req_drop",   {31'b0, bus_m.data_req}, 32'h0);
        check("rr_stall_drop", {31'b0, stall_m}, 32'h0);
        @(negedge clk);
        rst_i = 1'b1; ce = 1'b0;
        #1 bus_m.data_data_ok = 1'b1; bus_m.data_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        #1 bus_m.data_data_ok = 1'b0;
        check("rr_rdata", rdata_m, 32'h0);
        check("rr_req_idle", {31'b0, bus_m.data_req}, 32'h0);
        @(negedge clk);
        do_access(1'b0, 4'hF, 32'h8000_0050, 32'h0, 0, 1, 32'h7777_8888,
                  ns, nr, ra, ran, rsz, rwr, rwd, stab, dn);
        check("rr_next_stall", ns, 32'd3);
        check("rr_next_rdata", rdata_m, 32'h7777_8888);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
